regfile_writeback_queue: RTL

//   Writer side of the 32x32 register file (write port: pos/writevalue, written every posedge, no enable).

---
 rtl/regfile_writeback_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the 32x32 register file: two producers in, one register-file write out per cycle.
// Optional REGFILE_WB_DROP_R0_EN: handshake dest==0 requests but never enqueue them.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_value,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_value,
  output logic [ADDR_W-1:0] wr_pos,
  output logic [DATA_W-1:0] wr_value,
  input  logic [ADDR_W-1:0] look_pos1,
  output logic              look_hit1,
  output logic [DATA_W-1:0] look_value1,
  input  logic [ADDR_W-1:0] look_pos2,
  output logic              look_hit2,
  output logic [DATA_W-1:0] look_value2,
  output logic [CNT_W-1:0]  q_count,
  output logic              q_full,
  output logic              q_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

  logic [ADDR_W-1:0] dest_q  [DEPTH];
  logic [ADDR_W-1:0] dest_d  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_pos_q, wr_pos_d;
  logic [DATA_W-1:0] wr_value_q, wr_value_d;

  logic              mem_keep, alu_keep;
  logic              push_mem, push_alu, pop;
  logic [PTR_W-1:0]  alu_slot;
  logic [PTR_W-1:0]  slot_idx  [DEPTH];
  logic              slot_live [DEPTH];

  // Ready uses only the registered count, so a pop in the same cycle never frees space early.
  always_comb begin
    mem_ready = !reset && (count_q < DEPTH_C);
    alu_ready = !reset && ((count_q < DEPTH_M1_C) || ((count_q < DEPTH_C) && !mem_valid));
  end

`ifdef REGFILE_WB_DROP_R0_EN
  assign mem_keep = (mem_dest != '0);
  assign alu_keep = (alu_dest != '0);
`else
  assign mem_keep = 1'b1;
  assign alu_keep = 1'b1;
`endif

  assign push_mem = mem_valid && mem_ready && mem_keep;
  assign push_alu = alu_valid && alu_ready && alu_keep;
  assign pop      = (count_q != '0);
  assign alu_slot = push_mem ? tail_q + PTR_W'(1) : tail_q;

  always_comb begin
    dest_d     = dest_q;
    value_d    = value_q;
    head_d     = head_q;
    wr_pos_d   = '0;
    wr_value_d = '0;
    if (push_mem) begin
      dest_d[tail_q]  = mem_dest;
      value_d[tail_q] = mem_value;
    end
    if (push_alu) begin
      dest_d[alu_slot]  = alu_dest;
      value_d[alu_slot] = alu_value;
    end
    if (pop) begin
      wr_pos_d   = dest_q[head_q];
      wr_value_d = value_q[head_q];
      head_d     = head_q + PTR_W'(1);
    end
    tail_d  = tail_q + PTR_W'(push_mem) + PTR_W'(push_alu);
    count_d = count_q + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_pos_q   <= '0;
      wr_value_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_pos_q   <= wr_pos_d;
      wr_value_q <= wr_value_d;
    end
  end

  // Entry storage carries no reset; liveness comes from head/count alone.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      dest_q[gi]  <= dest_d[gi];
      value_q[gi] <= value_d[gi];
    end
    assign slot_idx[gi]  = head_q + PTR_W'(gi);
    assign slot_live[gi] = (CNT_W'(gi) < count_q);
  end

  // Slots are visited oldest to youngest, so the last match wins.
  always_comb begin
    look_hit1   = 1'b0;
    look_value1 = '0;
    look_hit2   = 1'b0;
    look_value2 = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_live[i] && (look_pos1 != '0) && (dest_q[slot_idx[i]] == look_pos1)) begin
          look_hit1   = 1'b1;
          look_value1 = value_q[slot_idx[i]];
        end
        if (slot_live[i] && (look_pos2 != '0) && (dest_q[slot_idx[i]] == look_pos2)) begin
          look_hit2   = 1'b1;
          look_value2 = value_q[slot_idx[i]];
        end
      end
    end
  end

  assign wr_pos   = wr_pos_q;
  assign wr_value = wr_value_q;
  assign q_count  = count_q;
  assign q_full   = (count_q == DEPTH_C);
  assign q_empty  = (count_q == '0);

endmodule
